// File: rtl/bridge_pkg.sv
// Shared types and constants for the CPU-word to peripheral-byte bridge.
package bridge_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StRdIssue,
    StRdWait,
    StResp
  } state_e;

  localparam int unsigned LANES    = 4;
  localparam logic [7:0]  ERR_BYTE = 8'hFF;

  typedef logic [$clog2(LANES)-1:0] lane_t;

endpackage

// File: rtl/bridge_timer.sv
// Per-byte read wait counter; saturates at TIMEOUT-1 and flags expiry there.
module bridge_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  logic [7:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == 8'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !expired_o) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/byte_bus_bridge.sv
// Splits 32-bit CPU loads/stores into four byte-lane peripheral accesses and
// reassembles read bytes; each read byte is guarded by a timeout.
module byte_bus_bridge
  import bridge_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned PADDR_W = 2,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [31:0]        req_wdata,
  input  logic [3:0]         req_wstrb,
  output logic               rsp_valid,
  output logic [31:0]        rsp_rdata,
  output logic               rsp_err,
  output logic               per_rd_en,
  output logic               per_wr_en,
  output logic [PADDR_W-1:0] per_addr,
  output logic [7:0]         per_wr_data,
  input  logic [7:0]         per_rd_data,
  input  logic               per_rd_valid
);

  state_e              state_q, state_d;
  lane_t               lane_q, lane_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          wstrb_q, wstrb_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;

  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [31:0]         rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                per_rd_en_q, per_rd_en_d;
  logic                per_wr_en_q, per_wr_en_d;
  logic [PADDR_W-1:0]  per_addr_q, per_addr_d;
  logic [7:0]          per_wr_data_q, per_wr_data_d;

  logic                accept;
  logic                tmr_expired;
  logic [PADDR_W-1:0]  lane_addr;

  assign accept = req_valid & req_ready_q;

  bridge_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (state_q != StRdWait),
    .inc_i     ((state_q == StRdWait) & ~per_rd_valid),
    .expired_o (tmr_expired)
  );

  if (PADDR_W > 2) begin : g_addr_wide
    assign lane_addr = {addr_d[PADDR_W-1:2], lane_d};
  end else begin : g_addr_narrow
    assign lane_addr = lane_d[PADDR_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          rdata_d = '0;
          lane_d  = '0;
          err_d   = 1'b0;
          state_d = req_we ? StWr : StRdIssue;
        end
      end
      StWr: begin
        if (lane_q == lane_t'(LANES - 1)) begin
          state_d = StResp;
        end else begin
          lane_d = lane_q + 1'b1;
        end
      end
      StRdIssue: state_d = StRdWait;
      StRdWait: begin
        // Valid data on the expiry cycle wins over the error byte.
        if (per_rd_valid || tmr_expired) begin
          rdata_d[8*lane_q +: 8] = per_rd_valid ? per_rd_data : ERR_BYTE;
          if (!per_rd_valid) begin
            err_d = 1'b1;
          end
          if (lane_q == lane_t'(LANES - 1)) begin
            state_d = StResp;
          end else begin
            lane_d  = lane_q + 1'b1;
            state_d = StRdIssue;
          end
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered, so they are derived from the next state and lane.
  always_comb begin
    req_ready_d   = (state_d == StIdle);
    rsp_valid_d   = (state_d == StResp);
    rsp_err_d     = rsp_valid_d & err_d;
    rsp_rdata_d   = (rsp_valid_d && !we_d) ? rdata_d : '0;
    per_rd_en_d   = (state_d == StRdIssue);
    per_wr_en_d   = (state_d == StWr) & wstrb_d[lane_d];
    per_addr_d    = per_addr_q;
    per_wr_data_d = per_wr_data_q;
    if (state_d == StWr || state_d == StRdIssue) begin
      per_addr_d = lane_addr;
    end
    if (state_d == StWr) begin
      per_wr_data_d = wdata_d[8*lane_d +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      lane_q        <= '0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      rdata_q       <= '0;
      err_q         <= 1'b0;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      per_rd_en_q   <= 1'b0;
      per_wr_en_q   <= 1'b0;
      per_addr_q    <= '0;
      per_wr_data_q <= '0;
    end else begin
      state_q       <= state_d;
      lane_q        <= lane_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      rdata_q       <= rdata_d;
      err_q         <= err_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      per_rd_en_q   <= per_rd_en_d;
      per_wr_en_q   <= per_wr_en_d;
      per_addr_q    <= per_addr_d;
      per_wr_data_q <= per_wr_data_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign per_rd_en   = per_rd_en_q;
  assign per_wr_en   = per_wr_en_q;
  assign per_addr    = per_addr_q;
  assign per_wr_data = per_wr_data_q;

endmodule

// File: doc/byte_bus_bridge.md
Name: byte_bus_bridge

Overview:
- Converts 32-bit CPU load/store requests into sequences of byte-wide accesses on the peripheral bus, the rd_en/wr_en/addr/rd_data/rd_valid bus used by the LED PWM block.
- Sits directly upstream of byte peripherals such as the LED controller.
- Splits each word into four byte-lane accesses and reassembles read bytes into one word response.
- Guards every peripheral read with a timeout so a non-responding peripheral cannot hang the CPU.

Parameters:
- ADDR_W, 8: CPU request byte-address width.
- PADDR_W, 2: peripheral address width. per_addr is {req_addr[PADDR_W-1:2], lane} when PADDR_W>2, and lane[PADDR_W-1:0] otherwise.
- TIMEOUT, 15: maximum cycles spent in RD_WAIT per byte before the bridge substitutes an error byte. Must be 1..255.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  CPU request present
- req_ready  out  1  bridge can accept a request
- req_we  in  1  1=write, 0=read
- req_addr  in  ADDR_W  byte address; bits [1:0] ignored (word aligned)
- req_wdata  in  32  write data, lane n = bits [8n+7:8n]
- req_wstrb  in  4  write byte enables
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  read data, valid with rsp_valid; 0 for writes
- rsp_err  out  1  a read byte timed out; valid with rsp_valid
- per_rd_en  out  1  peripheral read strobe
- per_wr_en  out  1  peripheral write strobe
- per_addr  out  PADDR_W  peripheral byte address
- per_wr_data  out  8  peripheral write byte
- per_rd_data  in  8  peripheral read byte
- per_rd_valid  in  1  per_rd_data valid this cycle

Behaviour:
- Clock is clk. Reset rst_n is asynchronous and active-low.
- While in reset: state=IDLE; req_ready=1; rsp_valid, rsp_err, per_rd_en, per_wr_en=0; rsp_rdata, per_addr, per_wr_data, and the lane and timer counters =0.
- All outputs are registered.
- States:
  - IDLE: req_ready=1. A handshake (req_valid & req_ready) latches we/addr/wdata/wstrb, sets lane=0 and clears err. Next state is WR when we=1, otherwise RD_ISSUE.
  - WR: one cycle per lane, lanes 0..3 in order. per_addr is driven for the current lane and per_wr_data=wdata lane byte; per_wr_en=wstrb[lane]. An unset strobe still consumes the cycle with no pulse. After lane 3 the next state is RESP.
  - RD_ISSUE: one cycle with per_rd_en=1 and per_addr for the lane; timer=0. Next state is RD_WAIT.
  - RD_WAIT: per_rd_en=0.
    - On per_rd_valid, store per_rd_data into rdata lane.
    - Else, if timer==TIMEOUT-1, store 8'hFF into the lane and set err (sticky per request).
    - Else timer increments.
    - On either store: if lane==3 go to RESP, else lane++ and go to RD_ISSUE.
  - RESP: rsp_valid=1 for exactly one cycle with rsp_rdata (0 for writes) and rsp_err. Next state is IDLE.
- req_ready=0 in every state except IDLE. Back-to-back requests are separated by at least one IDLE cycle after the RESP cycle.
- Timing, with E0 = the accept edge and a peripheral answering one cycle after per_rd_en (as the LED block does):
  - write: per_wr_en cycles 1..4 after E0, rsp_valid cycle 5;
  - read: per_rd_en cycles 1, 3, 5, 7, rsp_valid cycle 9.
- All four lanes are always read; there are no read strobes.
- per_rd_valid outside RD_WAIT is ignored, including a late response after a timeout.
- per_rd_valid on the same cycle the timer expires: valid data wins and err stays unchanged.
- Reset asserted mid-transaction aborts immediately. No rsp_valid is produced for the aborted request. The first cycle after reset release is IDLE.
- req_valid may drop without acceptance; the bridge does not require it to be held.

Decomposition:
- Package bridge_pkg holds:
  - the state enum (IDLE, WR, RD_ISSUE, RD_WAIT, RESP);
  - LANES=4;
  - ERR_BYTE=8'hFF;
  - a lane-index typedef.
- One sub-module, bridge_timer: a resettable up-counter with clear and an expired flag, parameterised by TIMEOUT.
- The FSM, lane sequencing and data assembly stay in byte_bus_bridge.

Test Plan:
- Write: addr=0x00, wdata=0x11223344, wstrb=4'b1111 -> per_wr_en on 4 consecutive cycles with (per_addr, per_wr_data) = (0,44), (1,33), (2,22), (3,11); rsp_valid 5 cycles after accept; rsp_err=0.
- Partial write: wstrb=4'b0101, wdata=0xAABBCCDD -> per_wr_en pulses only for (0,DD) and (2,BB); still 4 lane cycles; rsp_valid at cycle 5.
- Read with 1-cycle peripheral returning bytes 0x10, 0x20, 0x30, 0x40 -> per_rd_en at cycles 1, 3, 5, 7; rsp_rdata=0x40302010; rsp_err=0; rsp_valid at cycle 9.
- Timeout: peripheral never answers lane 2, TIMEOUT=15; the others return 0xA5 -> rsp_rdata=0xA5FFA5A5 and rsp_err=1. A stray per_rd_valid injected after the timeout does not corrupt lane 3.
- Handshake: req_valid held continuously with two requests -> req_ready=0 from the accept edge through the RESP cycle; the second accept occurs only in the IDLE cycle after rsp_valid.
- Reset mid-read: deassert rst_n during RD_WAIT of lane 1 -> all outputs 0 and req_ready=1 asynchronously; no rsp_valid after release; a new read then completes normally.
